// File: rtl/risc_pkg.sv
// risc_pkg: shared types and constants for the multi-cycle accumulator core.
//   opcode_t : the 8-opcode accumulator ISA (3-bit field at the top of the word)
//   state_t  : control FSM states; the 3-bit encoding is exported on `phase`
package risc_pkg;

  localparam int OPCODE_W = 3;

  typedef enum logic [2:0] {
    OP_HLT = 3'd0,
    OP_SKZ = 3'd1,
    OP_ADD = 3'd2,
    OP_AND = 3'd3,
    OP_XOR = 3'd4,
    OP_LDA = 3'd5,
    OP_STO = 3'd6,
    OP_JMP = 3'd7
  } opcode_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXECUTE = 3'd3,
    ST_HALTED  = 3'd4
  } state_t;

  // Bit position of the opcode field's MSB within an instruction word.
  function automatic int opcode_msb(input int data_width);
    return data_width - 1;
  endfunction

endpackage

// File: rtl/risc_alu.sv
// risc_alu: combinational accumulator ALU.
//   opcode  in  3           instruction opcode
//   inA     in  DATA_WIDTH  accumulator
//   inB     in  DATA_WIDTH  memory read data
//   res     out DATA_WIDTH  new accumulator value (inA for non-ALU opcodes)
//   is_zero out 1           inA == 0, used by SKZ
module risc_alu
  import risc_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [2:0]            opcode,
  input  logic [DATA_WIDTH-1:0] inA,
  input  logic [DATA_WIDTH-1:0] inB,
  output logic [DATA_WIDTH-1:0] res,
  output logic                  is_zero
);

  opcode_t op;
  assign op = opcode_t'(opcode);

  always_comb begin
    res = inA;
    case (op)
      OP_ADD:  res = inA + inB;  // carry discarded, wraps modulo 2^DATA_WIDTH
      OP_AND:  res = inA & inB;
      OP_XOR:  res = inA ^ inB;
      OP_LDA:  res = inB;
      default: res = inA;        // STO and control opcodes leave ACC alone
    endcase
  end

  assign is_zero = (inA == '0);

endmodule

// File: rtl/risc_core_mc.sv
// risc_core_mc: parametrised multi-cycle accumulator RISC core.
//   clk        in  1           system clock, rising edge
//   rst        in  1           asynchronous active-low reset
//   resume     in  1           restarts fetch when HALTED
//   mem_req    out 1           memory request (FETCH, EXECUTE)
//   mem_we     out 1           1 = write (STO)
//   mem_addr   out ADDR_WIDTH  PC in FETCH, operand in EXECUTE
//   mem_wdata  out DATA_WIDTH  accumulator
//   mem_rdata  in  DATA_WIDTH  read data, valid with mem_ack
//   mem_ack    in  1           transaction completes at this edge
//   pc_counter out ADDR_WIDTH  program counter
//   acc_out    out DATA_WIDTH  accumulator
//   halt       out 1           high while HALTED
//   phase      out 3           FSM state encoding
module risc_core_mc
  import risc_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  resume,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  output logic [ADDR_WIDTH-1:0] pc_counter,
  output logic [DATA_WIDTH-1:0] acc_out,
  output logic                  halt,
  output logic [2:0]            phase
);

  localparam int OP_MSB = opcode_msb(DATA_WIDTH);

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] pc, pc_nxt;
  logic [DATA_WIDTH-1:0] acc, acc_nxt;
  // IR keeps only the fields the ISA decodes; bits between them are ignored.
  opcode_t               ir_op, ir_op_nxt;
  logic [ADDR_WIDTH-1:0] ir_opd, ir_opd_nxt;

  logic [DATA_WIDTH-1:0] alu_res;
  logic                  acc_zero;

  risc_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .opcode  (ir_op),
    .inA     (acc),
    .inB     (mem_rdata),
    .res     (alu_res),
    .is_zero (acc_zero)
  );

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    acc_nxt    = acc;
    ir_op_nxt  = ir_op;
    ir_opd_nxt = ir_opd;
    case (state)
      ST_IDLE: state_nxt = ST_FETCH;
      ST_FETCH: begin
        if (mem_ack) begin
          ir_op_nxt  = opcode_t'(mem_rdata[OP_MSB -: OPCODE_W]);
          ir_opd_nxt = mem_rdata[ADDR_WIDTH-1:0];
          state_nxt  = ST_DECODE;
        end
      end
      ST_DECODE: begin
        pc_nxt = pc + ADDR_WIDTH'(1);
        case (ir_op)
          OP_HLT: state_nxt = ST_HALTED;
          OP_SKZ: begin
            // Skip lands two words past the SKZ itself, wrapping like any PC step.
            if (acc_zero) pc_nxt = pc + ADDR_WIDTH'(2);
            state_nxt = ST_FETCH;
          end
          OP_JMP: begin
            pc_nxt    = ir_opd;
            state_nxt = ST_FETCH;
          end
          default: state_nxt = ST_EXECUTE;
        endcase
      end
      ST_EXECUTE: begin
        if (mem_ack) begin
          acc_nxt   = alu_res;
          state_nxt = ST_FETCH;
        end
      end
      ST_HALTED: begin
        // PC already points past the HLT, so fetch simply continues.
        if (resume) state_nxt = ST_FETCH;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      pc     <= '0;
      acc    <= '0;
      ir_op  <= OP_HLT;
      ir_opd <= '0;
    end else begin
      state  <= state_nxt;
      pc     <= pc_nxt;
      acc    <= acc_nxt;
      ir_op  <= ir_op_nxt;
      ir_opd <= ir_opd_nxt;
    end
  end

  // Port drive is decoded from registered state only, so address, direction
  // and data stay stable for the whole request, and an asynchronous reset
  // drops mem_req in the same cycle.
  assign mem_req    = (state == ST_FETCH) || (state == ST_EXECUTE);
  assign mem_we     = (state == ST_EXECUTE) && (ir_op == OP_STO);
  assign mem_addr   = (state == ST_EXECUTE) ? ir_opd : pc;
  assign mem_wdata  = acc;
  assign pc_counter = pc;
  assign acc_out    = acc;
  assign halt       = (state == ST_HALTED);
  assign phase      = state;

endmodule

// File: tb/tb_risc_core_mc.sv
// Testbench for risc_core_mc: an 8-bit/5-bit core checked by a transaction
// scoreboard fed from an ISA-level reference model, and a 16-bit/12-bit core
// exercised with a short directed program and a reset during a memory wait.
module tb_risc_core_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 8-bit / 5-bit instance
  logic       rst8, resume8, mem_req8, mem_we8, mem_ack8, halt8;
  logic [4:0] mem_addr8, pc8;
  logic [7:0] mem_wdata8, mem_rdata8, acc8;
  logic [2:0] phase8;

  // 16-bit / 12-bit instance
  logic        rst16, resume16, mem_req16, mem_we16, mem_ack16, halt16;
  logic [11:0] mem_addr16, pc16;
  logic [15:0] mem_wdata16, mem_rdata16, acc16;
  logic [2:0]  phase16;

  risc_core_mc #(.DATA_WIDTH(8), .ADDR_WIDTH(5)) dut8 (
    .clk(clk), .rst(rst8), .resume(resume8),
    .mem_req(mem_req8), .mem_we(mem_we8), .mem_addr(mem_addr8),
    .mem_wdata(mem_wdata8), .mem_rdata(mem_rdata8), .mem_ack(mem_ack8),
    .pc_counter(pc8), .acc_out(acc8), .halt(halt8), .phase(phase8)
  );

  risc_core_mc #(.DATA_WIDTH(16), .ADDR_WIDTH(12)) dut16 (
    .clk(clk), .rst(rst16), .resume(resume16),
    .mem_req(mem_req16), .mem_we(mem_we16), .mem_addr(mem_addr16),
    .mem_wdata(mem_wdata16), .mem_rdata(mem_rdata16), .mem_ack(mem_ack16),
    .pc_counter(pc16), .acc_out(acc16), .halt(halt16), .phase(phase16)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------- memories ----------------
  logic [7:0]  mem8    [32];
  logic [7:0]  mdl_mem [32];
  logic [15:0] mem16   [4096];

  function automatic logic [7:0] ins8(input int op, input int opd);
    return {3'(op), 5'(opd)};
  endfunction

  // Bit 12 (between opcode and operand) is set to show it is ignored.
  function automatic logic [15:0] ins16(input int op, input int opd);
    return {3'(op), 1'b1, 12'(opd)};
  endfunction

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [4:0] addr;
    logic       we;
    logic [7:0] wdata;
  } txn_t;

  txn_t       exp_q[$];
  logic [4:0] mdl_pc;
  logic [7:0] mdl_acc;

  // Interprets the program instruction by instruction, queueing every memory
  // transaction the core must issue. `resumes` HLTs are stepped over.
  task automatic run_model(input int resumes);
    int r, steps;
    bit done;
    logic [7:0] ir;
    logic [2:0] op;
    logic [4:0] opd;
    r = resumes; steps = 0; done = 0;
    mdl_pc = '0; mdl_acc = '0;
    for (int i = 0; i < 32; i++) mdl_mem[i] = mem8[i];
    while (!done && steps < 300) begin
      steps++;
      ir  = mdl_mem[mdl_pc];
      op  = ir[7:5];
      opd = ir[4:0];
      exp_q.push_back('{addr: mdl_pc, we: 1'b0, wdata: 8'h00});
      mdl_pc = mdl_pc + 5'd1;
      case (op)
        3'd0: if (r > 0) r--; else done = 1;
        3'd1: if (mdl_acc == 8'd0) mdl_pc = mdl_pc + 5'd1;
        3'd7: mdl_pc = opd;
        default: begin
          exp_q.push_back('{addr: opd, we: (op == 3'd6), wdata: mdl_acc});
          case (op)
            3'd2: mdl_acc = mdl_acc + mdl_mem[opd];
            3'd3: mdl_acc = mdl_acc & mdl_mem[opd];
            3'd4: mdl_acc = mdl_acc ^ mdl_mem[opd];
            3'd5: mdl_acc = mdl_mem[opd];
            default: mdl_mem[opd] = mdl_acc;
          endcase
        end
      endcase
    end
  endtask

  // ---------------- memory responder (8-bit) ----------------
  int wait_cfg = 0;
  bit wait_rand = 0;
  int left8 = -1;

  initial begin
    mem_ack8 = 1'b0;
    mem_rdata8 = '0;
    forever begin
      @(negedge clk);
      if (rst8 === 1'b1 && mem_req8 === 1'b1) begin
        if (left8 < 0) left8 = wait_rand ? int'($urandom_range(3, 0)) : wait_cfg;
        if (left8 == 0) begin
          mem_ack8   = 1'b1;
          mem_rdata8 = mem_we8 ? 8'($urandom) : mem8[mem_addr8];
          left8      = -1;
        end else begin
          mem_ack8   = 1'b0;
          mem_rdata8 = 8'($urandom);
          left8--;
        end
      end else begin
        // With no request outstanding the ack line is noise the core must ignore.
        mem_ack8   = wait_rand ? 1'($urandom_range(1, 0)) : 1'b0;
        mem_rdata8 = 8'($urandom);
        left8      = -1;
      end
    end
  end

  // ---------------- monitor / scoreboard (8-bit) ----------------
  logic [4:0] hold_addr;
  logic       hold_we;
  logic [7:0] hold_wd;
  bit         hold_v = 0;
  txn_t       got;

  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst8 !== 1'b1 || mem_req8 !== 1'b1) begin
        hold_v = 0;
      end else begin
        if (hold_v) begin
          chk("hold_addr", 32'(mem_addr8), 32'(hold_addr));
          chk("hold_we", 32'(mem_we8), 32'(hold_we));
          if (hold_we) chk("hold_wdata", 32'(mem_wdata8), 32'(hold_wd));
        end else begin
          hold_addr = mem_addr8; hold_we = mem_we8; hold_wd = mem_wdata8; hold_v = 1;
        end
        if (mem_ack8 === 1'b1) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL txn_extra: got request at 0x%0h, expected none", mem_addr8);
          end else begin
            got = exp_q.pop_front();
            chk("txn_addr", 32'(mem_addr8), 32'(got.addr));
            chk("txn_we", 32'(mem_we8), 32'(got.we));
            if (got.we) chk("txn_wdata", 32'(mem_wdata8), 32'(got.wdata));
          end
          if (mem_we8) mem8[mem_addr8] = mem_wdata8;
          hold_v = 0;
        end
      end
    end
  end

  // ---------------- memory responder (16-bit), two wait states ----------------
  int left16 = -1;

  initial begin
    mem_ack16 = 1'b0;
    mem_rdata16 = '0;
    forever begin
      @(negedge clk);
      if (rst16 === 1'b1 && mem_req16 === 1'b1) begin
        if (left16 < 0) left16 = 2;
        if (left16 == 0) begin
          mem_ack16   = 1'b1;
          mem_rdata16 = mem16[mem_addr16];
          if (mem_we16) mem16[mem_addr16] = mem_wdata16;
          left16      = -1;
        end else begin
          mem_ack16 = 1'b0;
          left16--;
        end
      end else begin
        mem_ack16 = 1'b0;
        left16    = -1;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic rst_low8();
    @(negedge clk);
    rst8 = 1'b0;
    for (int i = 0; i < 32; i++) mem8[i] = 8'h00;
  endtask

  task automatic start8(input int resumes);
    exp_q.delete();
    run_model(resumes);
    @(negedge clk);
    rst8 = 1'b1;
  endtask

  task automatic wait_halt8(input int budget);
    int cyc;
    cyc = 0;
    while (halt8 !== 1'b1 && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    chk("halt_reached", 32'(halt8), 1);
  endtask

  task automatic wait_phase8(input string name, input logic [2:0] ph, input int budget);
    int cyc;
    cyc = 0;
    while (phase8 !== ph && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    chk(name, 32'(phase8), 32'(ph));
  endtask

  task automatic end_check8(input string tag);
    int bad;
    bad = 0;
    chk({tag, "_pc"}, 32'(pc8), 32'(mdl_pc));
    chk({tag, "_acc"}, 32'(acc8), 32'(mdl_acc));
    chk({tag, "_txn_left"}, 32'(exp_q.size()), 0);
    for (int i = 0; i < 32; i++) if (mem8[i] !== mdl_mem[i]) bad++;
    chk({tag, "_mem_diff"}, 32'(bad), 0);
  endtask

  task automatic run_skz(input logic [7:0] val, input int exp_pc);
    rst_low8();
    wait_cfg = 0;
    mem8[0] = ins8(5, 20); mem8[1] = ins8(7, 3); mem8[3] = ins8(1, 0);
    mem8[4] = ins8(0, 0);  mem8[5] = ins8(0, 0); mem8[20] = val;
    start8(0);
    wait_halt8(100);
    chk("skz_pc", 32'(pc8), 32'(exp_pc));
    end_check8("skz");
  endtask

  // ---------------- main stimulus ----------------
  int cyc, chg, bad, r_op, r_opd;
  logic [7:0] prev;

  initial begin
    rst8 = 1'b1; rst16 = 1'b1; resume8 = 1'b0; resume16 = 1'b0;
    for (int i = 0; i < 4096; i++) mem16[i] = 16'h0000;
    #1;
    rst8 = 1'b0; rst16 = 1'b0;

    // Reset values
    rst_low8();
    #1;
    chk("rst_pc", 32'(pc8), 0);
    chk("rst_acc", 32'(acc8), 0);
    chk("rst_halt", 32'(halt8), 0);
    chk("rst_req", 32'(mem_req8), 0);
    chk("rst_we", 32'(mem_we8), 0);
    chk("rst_addr", 32'(mem_addr8), 0);
    chk("rst_wdata", 32'(mem_wdata8), 0);
    chk("rst_phase", 32'(phase8), 0);

    // LDA/ADD/STO/HLT with ADD wrap, zero wait states
    mem8[0] = ins8(5, 10); mem8[1] = ins8(2, 11); mem8[2] = ins8(6, 12); mem8[3] = ins8(0, 0);
    mem8[10] = 8'h05; mem8[11] = 8'hFB; mem8[12] = 8'h77;
    wait_cfg = 0; wait_rand = 0;
    start8(0);
    @(negedge clk);
    chk("first_fetch_phase", 32'(phase8), 1);
    chk("first_fetch_req", 32'(mem_req8), 1);
    cyc = 0;
    while (halt8 !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("prog_cycles", 32'(cyc), 11);
    chk("prog_acc", 32'(acc8), 32'h00);
    chk("prog_mem12", 32'(mem8[12]), 32'h00);
    chk("prog_pc", 32'(pc8), 4);
    end_check8("prog");

    // SKZ taken / not taken
    run_skz(8'h00, 6);
    run_skz(8'h01, 5);

    // JMP 31, SKZ at 31 wraps the fetch address to 1
    rst_low8();
    mem8[0] = ins8(7, 31); mem8[31] = ins8(1, 0); mem8[1] = ins8(0, 0);
    start8(0);
    wait_halt8(100);
    chk("wrap_pc", 32'(pc8), 2);
    end_check8("wrap");

    // LDA with three wait states on every ack
    rst_low8();
    mem8[0] = ins8(5, 10); mem8[1] = ins8(0, 0); mem8[10] = 8'h5A;
    wait_cfg = 3;
    start8(0);
    @(negedge clk);
    prev = acc8; chg = 0; cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (acc8 !== prev) chg++;
      prev = acc8;
    end while (!(phase8 == 3'd1 && pc8 == 5'd1) && cyc < 100);
    chk("wait_lda_cycles", 32'(cyc), 9);
    chk("wait_lda_loads", 32'(chg), 1);
    chk("wait_lda_acc", 32'(acc8), 32'h5A);
    wait_halt8(100);
    end_check8("wait_lda");

    // HLT, hold, resume; resume mid-EXECUTE and at the HLT DECODE edge ignored
    rst_low8();
    mem8[0] = ins8(0, 0); mem8[1] = ins8(5, 10); mem8[2] = ins8(2, 10); mem8[3] = ins8(0, 0);
    mem8[10] = 8'h33;
    wait_cfg = 2;
    start8(1);
    wait_halt8(100);
    chk("halt_pc", 32'(pc8), 1);
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (halt8 !== 1'b1 || mem_req8 !== 1'b0) bad++;
    end
    chk("halt_hold", 32'(bad), 0);
    resume8 = 1'b1;
    @(negedge clk);
    resume8 = 1'b0;
    chk("resume_halt", 32'(halt8), 0);
    chk("resume_phase", 32'(phase8), 1);
    chk("resume_addr", 32'(mem_addr8), 1);
    wait_phase8("exec_seen", 3'd3, 50);
    resume8 = 1'b1;
    @(negedge clk);
    resume8 = 1'b0;
    chk("exec_resume_phase", 32'(phase8), 3);
    cyc = 0;
    while (!(phase8 == 3'd2 && pc8 == 5'd3) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("hlt_decode_seen", 32'(phase8), 2);
    resume8 = 1'b1;
    @(negedge clk);
    resume8 = 1'b0;
    @(negedge clk);
    chk("decode_resume_halt", 32'(halt8), 1);
    chk("resume_acc", 32'(acc8), 32'h66);
    end_check8("resume");

    // Reset during an EXECUTE wait
    rst_low8();
    mem8[0] = ins8(5, 10); mem8[1] = ins8(2, 10); mem8[2] = ins8(0, 0); mem8[10] = 8'h21;
    wait_cfg = 3;
    start8(0);
    cyc = 0;
    while (!(phase8 == 3'd3 && pc8 == 5'd2) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("abort_exec_seen", 32'(phase8), 3);
    #2;
    rst8 = 1'b0;
    #1;
    chk("abort_req", 32'(mem_req8), 0);
    chk("abort_phase", 32'(phase8), 0);
    chk("abort_pc", 32'(pc8), 0);
    chk("abort_acc", 32'(acc8), 0);
    exp_q.delete();
    wait_cfg = 0;
    start8(0);
    @(negedge clk);
    chk("abort_refetch_addr", 32'(mem_addr8), 0);
    wait_halt8(100);
    chk("abort_final_acc", 32'(acc8), 32'h42);
    end_check8("abort");

    // Random straight-line programs with random wait states
    wait_rand = 1;
    for (int p = 0; p < 8; p++) begin
      rst_low8();
      for (int a = 0; a < 14; a++) begin
        r_op = int'($urandom_range(7, 1));
        if (r_op == 7) r_opd = int'($urandom_range(15, a + 1));
        else if (r_op == 1) r_opd = 0;
        else r_opd = int'($urandom_range(31, 16));
        mem8[a] = ins8(r_op, r_opd);
      end
      for (int d = 16; d < 32; d++) mem8[d] = 8'($urandom);
      start8(0);
      wait_halt8(3000);
      end_check8("rand");
    end
    wait_rand = 0;

    // 16-bit data / 12-bit address instance
    mem16[0] = ins16(5, 100); mem16[1] = ins16(2, 101);
    mem16[2] = ins16(6, 102); mem16[3] = ins16(0, 0);
    mem16[100] = 16'h8001; mem16[101] = 16'h8003;
    #1;
    chk("w16_rst_req", 32'(mem_req16), 0);
    chk("w16_rst_phase", 32'(phase16), 0);
    @(negedge clk);
    rst16 = 1'b1;
    cyc = 0;
    while (phase16 !== 3'd3 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("w16_exec_seen", 32'(phase16), 3);
    #2;
    rst16 = 1'b0;
    #1;
    chk("w16_abort_req", 32'(mem_req16), 0);
    chk("w16_abort_pc", 32'(pc16), 0);
    chk("w16_abort_acc", 32'(acc16), 0);
    chk("w16_abort_phase", 32'(phase16), 0);
    @(negedge clk);
    rst16 = 1'b1;
    @(negedge clk);
    chk("w16_refetch_phase", 32'(phase16), 1);
    chk("w16_refetch_addr", 32'(mem_addr16), 0);
    cyc = 0;
    while (halt16 !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("w16_halt", 32'(halt16), 1);
    chk("w16_acc", 32'(acc16), 32'h0004);
    chk("w16_mem102", 32'(mem16[102]), 32'h0004);
    chk("w16_pc", 32'(pc16), 4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
